// File: rtl/elevator_pkg.sv
// Shared constants and width helpers for the elevator front end.
// Imported by the button conditioner and its debounce cells.
package elevator_pkg;

    localparam int FLOORS       = 8;
    localparam int TICK_DIV     = 4;
    localparam int STABLE_TICKS = 3;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DIV_W = width_of(TICK_DIV);
    localparam int CNT_W = width_of(STABLE_TICKS);

endpackage

// File: rtl/debounce_cell.sv
// One push-button line: two-flop synchroniser, tick-sampled debouncer
// and a registered one-cycle pulse on each accepted rising level.
import elevator_pkg::*;

module debounce_cell #(
    parameter int STABLE_TICKS = elevator_pkg::STABLE_TICKS
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic raw,
    output logic pulse
);

    localparam int CW = width_of(STABLE_TICKS);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_TICKS - 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_stable;
    logic [CW-1:0] r_cnt;
    logic          r_pulse;

    logic w_differ;
    logic w_done;

    assign w_differ = (r_s2 != r_stable);
    assign w_done   = (r_cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
            r_pulse  <= 1'b0;
        end else begin
            r_s1    <= raw;
            r_s2    <= r_s1;
            r_pulse <= 1'b0;
            // A single matching tick discards any partial run.
            if (tick) begin
                if (!w_differ) begin
                    r_cnt <= '0;
                end else if (w_done) begin
                    r_stable <= r_s2;
                    r_cnt    <= '0;
                    r_pulse  <= r_s2;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign pulse = r_pulse;

endmodule

// File: rtl/call_button_conditioner.sv
// Front end for the elevator controller: turns 3*FLOORS raw buttons
// into one-cycle request pulses; impossible hall calls are never built.
import elevator_pkg::*;

module call_button_conditioner #(
    parameter int FLOORS       = elevator_pkg::FLOORS,
    parameter int TICK_DIV     = elevator_pkg::TICK_DIV,
    parameter int STABLE_TICKS = elevator_pkg::STABLE_TICKS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [FLOORS-1:0] btn_eb,
    input  logic [FLOORS-1:0] btn_up,
    input  logic [FLOORS-1:0] btn_down,
    output logic [FLOORS-1:0] req_eb,
    output logic [FLOORS-1:0] req_up,
    output logic [FLOORS-1:0] req_down,
    output logic              any_req
);

    localparam int DW = width_of(TICK_DIV);
    localparam logic [DW-1:0] DIV_MAX = DW'(TICK_DIV - 1);

    logic [DW-1:0]     r_div;
    logic              w_tick;
    logic [FLOORS-1:0] w_eb;
    logic [FLOORS-1:0] w_up;
    logic [FLOORS-1:0] w_down;
    logic              w_unused;

    assign w_tick = (r_div == DIV_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    for (genvar i = 0; i < FLOORS; i++) begin : g_eb
        debounce_cell #(
            .STABLE_TICKS(STABLE_TICKS)
        ) u_cell (
            .clk  (clk),
            .reset(reset),
            .tick (w_tick),
            .raw  (btn_eb[i]),
            .pulse(w_eb[i])
        );
    end

    // No up call from the top floor, no down call from the bottom.
    for (genvar i = 0; i < FLOORS - 1; i++) begin : g_up
        debounce_cell #(
            .STABLE_TICKS(STABLE_TICKS)
        ) u_cell (
            .clk  (clk),
            .reset(reset),
            .tick (w_tick),
            .raw  (btn_up[i]),
            .pulse(w_up[i])
        );
    end

    for (genvar i = 1; i < FLOORS; i++) begin : g_down
        debounce_cell #(
            .STABLE_TICKS(STABLE_TICKS)
        ) u_cell (
            .clk  (clk),
            .reset(reset),
            .tick (w_tick),
            .raw  (btn_down[i]),
            .pulse(w_down[i])
        );
    end

    assign w_up[FLOORS-1] = 1'b0;
    assign w_down[0]      = 1'b0;
    assign w_unused       = btn_up[FLOORS-1] ^ btn_down[0];

    assign req_eb   = w_eb;
    assign req_up   = w_up;
    assign req_down = w_down;
    assign any_req  = |{w_eb, w_up, w_down};

endmodule

// File: tb/tb_call_button_conditioner.sv
// Self-checking bench for call_button_conditioner with a
// history-based reference model of the debounce rules.
module tb_call_button_conditioner;

    localparam int TD = 4;
    localparam int ST = 3;
    localparam logic [23:0] MASK = 24'hFE7FFF;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] btn_eb, btn_up, btn_down;
    logic [7:0] req_eb, req_up, req_down;
    logic       any_req;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    call_button_conditioner dut (
        .clk     (clk),
        .reset   (reset),
        .btn_eb  (btn_eb),
        .btn_up  (btn_up),
        .btn_down(btn_down),
        .req_eb  (req_eb),
        .req_up  (req_up),
        .req_down(req_down),
        .any_req (any_req)
    );

    // Model: input seen two cycles late, sampled every TD cycles after
    // reset; a level is accepted after ST consecutive differing samples.
    logic [23:0] m_h1, m_h2, m_lvl, m_req;
    int          m_run [24];
    int          m_t;

    always @(posedge clk) begin
        logic [23:0] lvl_n;
        logic [23:0] req_n;
        int          run_n [24];
        if (reset) begin
            m_h1  <= '0;
            m_h2  <= '0;
            m_lvl <= '0;
            m_req <= '0;
            m_t   <= 0;
            for (int k = 0; k < 24; k++) m_run[k] <= 0;
        end else begin
            lvl_n = m_lvl;
            req_n = '0;
            for (int k = 0; k < 24; k++) begin
                run_n[k] = m_run[k];
                if (m_t % TD == TD - 1) begin
                    if (m_h2[k] == m_lvl[k]) begin
                        run_n[k] = 0;
                    end else begin
                        run_n[k] = m_run[k] + 1;
                        if (run_n[k] == ST) begin
                            lvl_n[k] = m_h2[k];
                            run_n[k] = 0;
                            req_n[k] = m_h2[k];
                        end
                    end
                end
            end
            m_h1  <= {btn_down, btn_up, btn_eb};
            m_h2  <= m_h1;
            m_lvl <= lvl_n;
            m_req <= req_n & MASK;
            m_t   <= m_t + 1;
            for (int k = 0; k < 24; k++) m_run[k] <= run_n[k];
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int n);
        btn_eb   = '0;
        btn_up   = '0;
        btn_down = '0;
        repeat (n) cyc();
    endtask

    task automatic test_reset();
        int f_eb = -1, f_up = -1, f_dn = -1;
        int n_eb = 0, n_up = 0, n_dn = 0;
        logic [7:0] v_eb = '0, v_up = '0, v_dn = '0;
        reset    = 1'b1;
        btn_eb   = 8'hFF;
        btn_up   = 8'hFF;
        btn_down = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if ({req_eb, req_up, req_down, any_req} !== 25'd0) begin
                errs++;
                $display("FAIL reset_hold cyc=%0d got=%h want=0", i,
                         {req_eb, req_up, req_down, any_req});
            end
        end
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (req_eb !== 8'h00) begin
                n_eb++;
                if (f_eb < 0) begin f_eb = i; v_eb = req_eb; end
            end
            if (req_up !== 8'h00) begin
                n_up++;
                if (f_up < 0) begin f_up = i; v_up = req_up; end
            end
            if (req_down !== 8'h00) begin
                n_dn++;
                if (f_dn < 0) begin f_dn = i; v_dn = req_down; end
            end
        end
        checks++;
        if (n_eb != 1 || n_up != 1 || n_dn != 1) begin
            errs++;
            $display("FAIL reset_held_count got=%0d/%0d/%0d want=1/1/1",
                     n_eb, n_up, n_dn);
        end
        checks++;
        if (f_eb < 10 || f_eb > 13 || f_up < 10 || f_up > 13 ||
            f_dn < 10 || f_dn > 13) begin
            errs++;
            $display("FAIL reset_held_latency got=%0d/%0d/%0d want=10..13",
                     f_eb, f_up, f_dn);
        end
        checks++;
        if (v_eb !== 8'hFF || v_up !== 8'h7F || v_dn !== 8'hFE) begin
            errs++;
            $display("FAIL reset_held_value got=%h/%h/%h want=ff/7f/fe",
                     v_eb, v_up, v_dn);
        end
        settle(30);
    endtask

    task automatic test_clean_press();
        int f = -1, n = 0, other = 0, anyok = 0;
        logic [7:0] v = '0;
        btn_eb = 8'h20;
        for (int i = 0; i < 70; i++) begin
            if (i == 40) btn_eb = 8'h00;
            cyc();
            if (req_eb !== 8'h00) begin
                n++;
                if (f < 0) begin f = i; v = req_eb; anyok = (any_req === 1'b1); end
            end
            if (req_up !== 8'h00 || req_down !== 8'h00) other++;
        end
        checks++;
        if (n != 1) begin
            errs++;
            $display("FAIL clean_count got=%0d want=1", n);
        end
        checks++;
        if (f < 10 || f > 13) begin
            errs++;
            $display("FAIL clean_latency got=%0d want=10..13", f);
        end
        checks++;
        if (v !== 8'h20) begin
            errs++;
            $display("FAIL clean_value got=%h want=20", v);
        end
        checks++;
        if (anyok != 1) begin
            errs++;
            $display("FAIL clean_any_req got=%0d want=1", anyok);
        end
        checks++;
        if (other != 0) begin
            errs++;
            $display("FAIL clean_other got=%0d want=0", other);
        end
        settle(30);
    endtask

    task automatic test_bounce();
        int f = -1, n = 0, early = 0;
        logic [7:0] v = '0;
        // Keep the last low bounce segment on a sample tick.
        for (int w = 0; w < 4 && (m_t % TD) == TD - 1; w++) cyc();
        for (int i = 0; i < 60; i++) begin
            btn_up[3] = (i < 30) ? (((i / 3) % 2) == 0) : 1'b1;
            cyc();
            if (req_up !== 8'h00) begin
                n++;
                if (i < 30) early++;
                if (f < 0) begin f = i; v = req_up; end
            end
        end
        checks++;
        if (early != 0) begin
            errs++;
            $display("FAIL bounce_early got=%0d want=0", early);
        end
        checks++;
        if (n != 1 || v !== 8'h08) begin
            errs++;
            $display("FAIL bounce_pulse got=%0d/%h want=1/08", n, v);
        end
        checks++;
        if (f - 30 < 10 || f - 30 > 13) begin
            errs++;
            $display("FAIL bounce_latency got=%0d want=10..13", f - 30);
        end
        settle(30);
    endtask

    task automatic test_glitch();
        int n = 0;
        for (int i = 0; i < 40; i++) begin
            btn_down[5] = (i < 6);
            cyc();
            if ({req_eb, req_up, req_down} !== 24'd0) n++;
        end
        checks++;
        if (n != 0) begin
            errs++;
            $display("FAIL glitch got=%0d pulses want=0", n);
        end
        settle(10);
    endtask

    task automatic test_mask_simul();
        int n = 0, anyok = 0;
        logic [23:0] v = '0;
        btn_eb   = 8'hFF;
        btn_up   = 8'hFF;
        btn_down = 8'hFF;
        for (int i = 0; i < 70; i++) begin
            if (i == 40) begin btn_eb = '0; btn_up = '0; btn_down = '0; end
            cyc();
            if ({req_eb, req_up, req_down} !== 24'd0) begin
                n++;
                v = {req_eb, req_up, req_down};
                anyok = (any_req === 1'b1);
            end
        end
        checks++;
        if (n != 1) begin
            errs++;
            $display("FAIL simul_count got=%0d want=1", n);
        end
        checks++;
        if (v !== 24'hFF7FFE || anyok != 1) begin
            errs++;
            $display("FAIL simul_value got=%h any=%0d want=ff7ffe any=1",
                     v, anyok);
        end
        settle(30);
    endtask

    task automatic test_reset_mid();
        int pre = 0, n = 0, f = -1;
        btn_eb = 8'h04;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (req_eb !== 8'h00) pre++;
        end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        checks++;
        if ({req_eb, req_up, req_down, any_req} !== 25'd0 || pre != 0) begin
            errs++;
            $display("FAIL midreset_pre got=%0d pulses out=%h want=0",
                     pre, {req_eb, any_req});
        end
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (req_eb !== 8'h00) begin
                n++;
                if (f < 0) f = i;
            end
        end
        checks++;
        if (n != 1 || f < 10 || f > 13) begin
            errs++;
            $display("FAIL midreset_post got=%0d@%0d want=1@10..13", n, f);
        end
        settle(30);
    endtask

    task automatic test_random();
        logic [23:0] v;
        int          len;
        for (int s = 0; s < 140; s++) begin
            v = {btn_down, btn_up, btn_eb};
            v[$urandom_range(0, 23)] ^= 1'b1;
            if ($urandom_range(0, 9) == 0) v = 24'($urandom);
            {btn_down, btn_up, btn_eb} = v;
            len = $urandom_range(1, 24);
            if ($urandom_range(0, 29) == 0) reset = 1'b1;
            for (int j = 0; j < len; j++) begin
                cyc();
                reset = 1'b0;
                checks++;
                if ({req_down, req_up, req_eb} !== m_req ||
                    any_req !== (|m_req)) begin
                    errs++;
                    $display("FAIL random seg=%0d got=%h/%b want=%h/%b",
                             s, {req_down, req_up, req_eb}, any_req,
                             m_req, |m_req);
                end
            end
        end
        settle(30);
    endtask

    initial begin
        reset    = 1'b1;
        btn_eb   = '0;
        btn_up   = '0;
        btn_down = '0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_mask_simul();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
